branch_predictor: RTL and testbench

//  Parametrised fetch-stage next-PC predictor replacing the fixed PC+4 prediction.

---
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals shared between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int DBITS   = 32,
  parameter int IDXBITS = 6
);
  logic [DBITS-1:0]   lk_pc;
  logic [DBITS-1:0]   lk_pred_pc;
  logic               lk_taken;
  logic [IDXBITS-1:0] lk_cidx;

  logic               upd_valid;
  logic [DBITS-1:0]   upd_pc;
  logic               upd_is_jmp;
  logic               upd_taken;
  logic [DBITS-1:0]   upd_target;
  logic [IDXBITS-1:0] upd_cidx;
  logic               upd_mispred;

  modport master (
    output lk_pc,
    input  lk_pred_pc, lk_taken, lk_cidx,
    output upd_valid, upd_pc, upd_is_jmp, upd_taken, upd_target, upd_cidx, upd_mispred
  );

  modport slave (
    input  lk_pc,
    output lk_pred_pc, lk_taken, lk_cidx,
    input  upd_valid, upd_pc, upd_is_jmp, upd_taken, upd_target, upd_cidx, upd_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB plus saturating direction counters (bimodal or gshare),
// looked up combinationally in fetch and trained from execute, with saturating statistics.
module branch_predictor #(
  parameter int DBITS    = 32,
  parameter int IDXBITS  = 6,
  parameter int TAGBITS  = 8,
  parameter int CTRBITS  = 2,
  parameter int MODE     = 0,
  parameter int HISTBITS = 4,
  parameter int STATBITS = 16,
  parameter int INSTSIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  branch_predictor_if.slave   bp,
  output logic [STATBITS-1:0] stat_br,
  output logic [STATBITS-1:0] stat_mis
);
  localparam int ENTRIES = 1 << IDXBITS;
  localparam logic [CTRBITS-1:0] CTR_INIT = CTRBITS'((1 << (CTRBITS - 1)) - 1);
  localparam logic [CTRBITS-1:0] CTR_MAX  = '1;

  logic                valid_q  [ENTRIES];
  logic [TAGBITS-1:0]  tag_q    [ENTRIES];
  logic [DBITS-1:0]    target_q [ENTRIES];
  logic                jmp_q    [ENTRIES];
  logic [CTRBITS-1:0]  ctr_q    [ENTRIES];
  logic [HISTBITS-1:0] ghr_q;

  logic [IDXBITS-1:0]  lk_idx, upd_idx, ghr_ext, lk_cidx_c;
  logic [TAGBITS-1:0]  lk_tag, upd_tag;
  logic [HISTBITS:0]   ghr_cat;
  logic                lk_hit, lk_taken_c;
  logic                unused_bits;

  assign lk_idx  = bp.lk_pc[IDXBITS+1:2];
  assign lk_tag  = bp.lk_pc[IDXBITS+TAGBITS+1:IDXBITS+2];
  assign upd_idx = bp.upd_pc[IDXBITS+1:2];
  assign upd_tag = bp.upd_pc[IDXBITS+TAGBITS+1:IDXBITS+2];
  assign ghr_cat = {ghr_q, bp.upd_taken};

  assign unused_bits = ^{bp.upd_pc, ghr_cat[HISTBITS]};

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HISTBITS-1:0] = ghr_q;
  end

  // While reset is held, the tables still hold stale contents; mask them so fetch sees PC+INSTSIZE.
  assign lk_cidx_c  = (MODE != 0 && !reset) ? (lk_idx ^ ghr_ext) : lk_idx;
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken_c = !reset && lk_hit && (jmp_q[lk_idx] || ctr_q[lk_cidx_c][CTRBITS-1]);

  assign bp.lk_taken   = lk_taken_c;
  assign bp.lk_cidx    = lk_cidx_c;
  assign bp.lk_pred_pc = lk_taken_c ? target_q[lk_idx] : bp.lk_pc + DBITS'(INSTSIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      ghr_q    <= '0;
      stat_br  <= '0;
      stat_mis <= '0;
    end else if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
      end
      if (!bp.upd_is_jmp) begin
        if (bp.upd_taken && ctr_q[bp.upd_cidx] != CTR_MAX) begin
          ctr_q[bp.upd_cidx] <= ctr_q[bp.upd_cidx] + CTRBITS'(1);
        end else if (!bp.upd_taken && ctr_q[bp.upd_cidx] != '0) begin
          ctr_q[bp.upd_cidx] <= ctr_q[bp.upd_cidx] - CTRBITS'(1);
        end
        if (MODE != 0) begin
          ghr_q <= ghr_cat[HISTBITS-1:0];
        end
      end
      if (stat_br != '1) begin
        stat_br <= stat_br + STATBITS'(1);
      end
      if (bp.upd_mispred && stat_mis != '1) begin
        stat_mis <= stat_mis + STATBITS'(1);
      end
    end
  end

  // Payload fields need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (!reset && bp.upd_valid && bp.upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.upd_target;
      jmp_q[upd_idx]    <= bp.upd_is_jmp;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance and a gshare instance with narrow statistics.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] stat_br0, stat_mis0;
  logic [3:0]  stat_br1, stat_mis1;

  branch_predictor_if #(.DBITS(32), .IDXBITS(6)) bp0 ();
  branch_predictor_if #(.DBITS(32), .IDXBITS(6)) bp1 ();

  branch_predictor #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bp(bp0), .stat_br(stat_br0), .stat_mis(stat_mis0)
  );

  branch_predictor #(.MODE(1), .HISTBITS(4), .STATBITS(4)) dut1 (
    .clk(clk), .reset(reset), .bp(bp1), .stat_br(stat_br1), .stat_mis(stat_mis1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd(input int d, input logic [31:0] pc, input logic jmp, input logic tk,
                     input logic [31:0] tgt, input logic [5:0] cidx, input logic mis);
    if (d == 0) begin
      bp0.upd_valid = 1'b1; bp0.upd_pc = pc; bp0.upd_is_jmp = jmp; bp0.upd_taken = tk;
      bp0.upd_target = tgt; bp0.upd_cidx = cidx; bp0.upd_mispred = mis;
    end else begin
      bp1.upd_valid = 1'b1; bp1.upd_pc = pc; bp1.upd_is_jmp = jmp; bp1.upd_taken = tk;
      bp1.upd_target = tgt; bp1.upd_cidx = cidx; bp1.upd_mispred = mis;
    end
    @(posedge clk);
    #1;
    bp0.upd_valid = 1'b0;
    bp1.upd_valid = 1'b0;
  endtask

  task automatic look(input int d, input logic [31:0] pc, input string tag,
                      input logic exp_tk, input logic [31:0] exp_pc);
    if (d == 0) begin
      bp0.lk_pc = pc;
      #1;
      check_val({tag, "_taken"}, bp0.lk_taken, exp_tk);
      check_val({tag, "_pred"}, bp0.lk_pred_pc, exp_pc);
    end else begin
      bp1.lk_pc = pc;
      #1;
      check_val({tag, "_taken"}, bp1.lk_taken, exp_tk);
      check_val({tag, "_pred"}, bp1.lk_pred_pc, exp_pc);
    end
  endtask

  initial begin
    reset = 1'b1;
    bp0.lk_pc = '0; bp0.upd_valid = 1'b0; bp0.upd_pc = '0; bp0.upd_is_jmp = 1'b0;
    bp0.upd_taken = 1'b0; bp0.upd_target = '0; bp0.upd_cidx = '0; bp0.upd_mispred = 1'b0;
    bp1.lk_pc = '0; bp1.upd_valid = 1'b0; bp1.upd_pc = '0; bp1.upd_is_jmp = 1'b0;
    bp1.upd_taken = 1'b0; bp1.upd_target = '0; bp1.upd_cidx = '0; bp1.upd_mispred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    look(0, 32'h100, "rst", 1'b0, 32'h104);
    check_val("rst_cidx", bp0.lk_cidx, 32'h0);
    check_val("rst_stat_br", stat_br0, 32'h0);
    check_val("rst_stat_mis", stat_mis0, 32'h0);
    check_val("rst_stat_br1", stat_br1, 32'h0);

    // Taken training at 0x120 (idx 8): ctr 1->2->3
    upd(0, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b1);
    look(0, 32'h120, "one_taken", 1'b1, 32'h200);
    check_val("one_stat_br", stat_br0, 32'd1);
    check_val("one_stat_mis", stat_mis0, 32'd1);
    upd(0, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b0);
    look(0, 32'h120, "two_taken", 1'b1, 32'h200);
    check_val("two_stat_mis", stat_mis0, 32'd1);

    // Saturation at top and bottom
    repeat (5) upd(0, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b0);
    upd(0, 32'h120, 1'b0, 1'b0, 32'h0, 6'd8, 1'b0);
    look(0, 32'h120, "sat_hi", 1'b1, 32'h200);
    repeat (2) upd(0, 32'h120, 1'b0, 1'b0, 32'h0, 6'd8, 1'b0);
    look(0, 32'h120, "ctr_zero", 1'b0, 32'h124);
    upd(0, 32'h120, 1'b0, 1'b0, 32'h0, 6'd8, 1'b0);
    upd(0, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b0);
    look(0, 32'h120, "sat_lo", 1'b0, 32'h124);
    upd(0, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b0);
    look(0, 32'h120, "ctr_two", 1'b1, 32'h200);

    // JAL at 0x140 (idx 16): taken regardless of counter, counter untouched
    upd(0, 32'h140, 1'b1, 1'b1, 32'h300, 6'd16, 1'b1);
    look(0, 32'h140, "jal", 1'b1, 32'h300);
    upd(0, 32'h140, 1'b0, 1'b1, 32'h300, 6'd16, 1'b0);
    look(0, 32'h140, "jal_cond_t", 1'b1, 32'h300);
    upd(0, 32'h140, 1'b0, 1'b0, 32'h0, 6'd16, 1'b0);
    look(0, 32'h140, "jal_ctr_kept", 1'b0, 32'h144);

    // Alias: 0x220 shares idx 8 with 0x120, different tag
    upd(0, 32'h220, 1'b0, 1'b1, 32'h400, 6'd8, 1'b0);
    look(0, 32'h120, "alias_old", 1'b0, 32'h124);
    look(0, 32'h220, "alias_new", 1'b1, 32'h400);
    check_val("stat_br_17", stat_br0, 32'd17);
    check_val("stat_mis_2", stat_mis0, 32'd2);

    look(0, 32'hFFFF_FFFC, "wrap", 1'b0, 32'h0);

    // Same-cycle lookup and update of one entry
    bp0.lk_pc = 32'h180;
    bp0.upd_valid = 1'b1; bp0.upd_pc = 32'h180; bp0.upd_is_jmp = 1'b1; bp0.upd_taken = 1'b1;
    bp0.upd_target = 32'h500; bp0.upd_cidx = 6'd32; bp0.upd_mispred = 1'b0;
    #1;
    check_val("same_cyc_old_taken", bp0.lk_taken, 1'b0);
    check_val("same_cyc_old_pred", bp0.lk_pred_pc, 32'h184);
    @(posedge clk);
    #1;
    bp0.upd_valid = 1'b0;
    check_val("same_cyc_new_taken", bp0.lk_taken, 1'b1);
    check_val("same_cyc_new_pred", bp0.lk_pred_pc, 32'h500);

    // gshare: T,N,T,T at 0x120 -> GHR 1011, cidx 8^B = 3
    upd(1, 32'h120, 1'b0, 1'b1, 32'h200, 6'd8, 1'b0);
    bp1.lk_pc = 32'h120;
    #1;
    check_val("gs_cidx_t", bp1.lk_cidx, 32'd9);
    upd(1, 32'h120, 1'b0, 1'b0, 32'h0, 6'd9, 1'b1);
    upd(1, 32'h120, 1'b0, 1'b1, 32'h200, 6'd10, 1'b0);
    upd(1, 32'h120, 1'b0, 1'b1, 32'h200, 6'd13, 1'b0);
    look(1, 32'h120, "gs_tntt", 1'b0, 32'h124);
    check_val("gs_cidx_b", bp1.lk_cidx, 32'd3);
    check_val("gs_stat_br", stat_br1, 32'd4);
    check_val("gs_stat_mis", stat_mis1, 32'd1);
    upd(1, 32'h140, 1'b1, 1'b1, 32'h300, 6'h1B, 1'b0);
    look(1, 32'h140, "gs_jal", 1'b1, 32'h300);
    check_val("gs_jal_cidx", bp1.lk_cidx, 32'h1B);
    bp1.lk_pc = 32'h120;
    #1;
    check_val("gs_ghr_kept", bp1.lk_cidx, 32'd3);
    check_val("gs_stat_mis_only", stat_mis1, 32'd1);
    repeat (16) upd(1, 32'h140, 1'b1, 1'b1, 32'h300, 6'h1B, 1'b1);
    check_val("gs_stat_br_sat", stat_br1, 32'd15);
    check_val("gs_stat_mis_sat", stat_mis1, 32'd15);

    // Reset mid-operation with a same-cycle update
    reset = 1'b1;
    bp0.upd_valid = 1'b1; bp0.upd_pc = 32'h1C0; bp0.upd_is_jmp = 1'b1; bp0.upd_taken = 1'b1;
    bp0.upd_target = 32'h600; bp0.upd_cidx = 6'd48; bp0.upd_mispred = 1'b1;
    bp0.lk_pc = 32'h220;
    bp1.lk_pc = 32'h120;
    #1;
    check_val("in_rst_taken", bp0.lk_taken, 1'b0);
    check_val("in_rst_pred", bp0.lk_pred_pc, 32'h224);
    check_val("in_rst_cidx", bp1.lk_cidx, 32'd8);
    @(posedge clk);
    #1;
    bp0.upd_valid = 1'b0;
    reset = 1'b0;
    look(0, 32'h1C0, "rst_drop_upd", 1'b0, 32'h1C4);
    look(0, 32'h220, "rst_clear", 1'b0, 32'h224);
    check_val("rst2_stat_br", stat_br0, 32'd0);
    check_val("rst2_stat_mis", stat_mis0, 32'd0);
    check_val("rst2_ghr", bp1.lk_cidx, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
